// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ttt_pkg;

  // Controller states: whose turn it is, board evaluation, game finished.
  typedef enum logic [1:0] {
    ST_TURN_A = 2'd0,
    ST_TURN_B = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int BOARD_W = 9;
  localparam logic [3:0] MAX_POS = 4'd8;
  localparam logic [BOARD_W-1:0] BOARD_FULL = 9'h1FF;

  // Winner codes; 2'b11 is never produced.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;

  // TURN state belonging to a player (0 = A, 1 = B).
  function automatic state_e turn_state(input logic player);
    return player ? ST_TURN_B : ST_TURN_A;
  endfunction

endpackage

// File: rtl/ttt_line_detect.sv
// Flags every completed three-in-a-row line on one player's occupancy board.
// Latency: combinational.
// Backpressure: none.
module ttt_line_detect
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] board_i,
  output logic [7:0]         lines_o
);

  // Bit order: rows top-down from square 8, columns from square 8, then both diagonals.
  always_comb begin
    lines_o    = '0;
    lines_o[0] = board_i[8] & board_i[7] & board_i[6];
    lines_o[1] = board_i[5] & board_i[4] & board_i[3];
    lines_o[2] = board_i[2] & board_i[1] & board_i[0];
    lines_o[3] = board_i[8] & board_i[5] & board_i[2];
    lines_o[4] = board_i[7] & board_i[4] & board_i[1];
    lines_o[5] = board_i[6] & board_i[3] & board_i[0];
    lines_o[6] = board_i[8] & board_i[4] & board_i[0];
    lines_o[7] = board_i[2] & board_i[4] & board_i[6];
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe referee: takes alternating moves, rejects bad squares, detects win/draw.
// Latency: move accepted in cycle N lands on the board at edge N+1; result one cycle later.
// Backpressure: a_ready/b_ready high only in the mover's TURN state; low in CHECK and DONE.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       a_valid,
  input  logic [3:0] a_pos,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [3:0] b_pos,
  output logic       b_ready,
  output logic [8:0] ain,
  output logic [8:0] bin,
  output logic       turn,
  output logic [7:0] win_line,
  output logic [1:0] winner,
  output logic       draw,
  output logic       game_over,
  output logic       illegal
);

  state_e             state_q, state_d;
  logic [BOARD_W-1:0] ain_q, ain_d, bin_q, bin_d;
  logic [7:0]         win_line_q, win_line_d;
  logic [1:0]         winner_q, winner_d;
  logic               draw_q, draw_d;
  logic               illegal_q, illegal_d;
  logic               mover_q, mover_d;   // player of the last legal move

  logic               mv_vld;
  logic [3:0]         mv_pos;
  logic [BOARD_W-1:0] mv_bit;
  logic               mv_legal;
  logic [7:0]         lines_a, lines_b, mover_lines;

  ttt_line_detect u_lines_a (.board_i(ain_q), .lines_o(lines_a));
  ttt_line_detect u_lines_b (.board_i(bin_q), .lines_o(lines_b));

  // Only the player whose turn it is can present a move; the other side is ignored.
  always_comb begin
    mv_vld = 1'b0;
    mv_pos = a_pos;
    if (state_q == ST_TURN_A) begin
      mv_vld = a_valid;
      mv_pos = a_pos;
    end else if (state_q == ST_TURN_B) begin
      mv_vld = b_valid;
      mv_pos = b_pos;
    end
    mv_bit      = BOARD_W'(1) << mv_pos;
    mv_legal    = (mv_pos <= MAX_POS) && (((ain_q | bin_q) & mv_bit) == '0);
    mover_lines = mover_q ? lines_b : lines_a;
  end

  // Next-state: clear overrides everything, otherwise step the game.
  always_comb begin
    state_d    = state_q;
    ain_d      = ain_q;
    bin_d      = bin_q;
    win_line_d = win_line_q;
    winner_d   = winner_q;
    draw_d     = draw_q;
    illegal_d  = 1'b0;
    mover_d    = mover_q;
    if (clear) begin
      state_d    = turn_state(FIRST_PLAYER);
      ain_d      = '0;
      bin_d      = '0;
      win_line_d = '0;
      winner_d   = WIN_NONE;
      draw_d     = 1'b0;
      mover_d    = FIRST_PLAYER;
    end else begin
      case (state_q)
        ST_TURN_A, ST_TURN_B: begin
          if (mv_vld) begin
            if (mv_legal) begin
              if (state_q == ST_TURN_A) ain_d = ain_q | mv_bit;
              else                      bin_d = bin_q | mv_bit;
              mover_d = (state_q == ST_TURN_B);
              state_d = ST_CHECK;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          // A win on the last square beats the full-board draw.
          if (mover_lines != '0) begin
            state_d    = ST_DONE;
            win_line_d = mover_lines;
            winner_d   = mover_q ? WIN_B : WIN_A;
          end else if ((ain_q | bin_q) == BOARD_FULL) begin
            state_d = ST_DONE;
            draw_d  = 1'b1;
          end else begin
            state_d = turn_state(!mover_q);
          end
        end
        default: ;  // ST_DONE holds until clear
      endcase
    end
  end

  // Game registers; reset drops straight back to the starting player's turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= turn_state(FIRST_PLAYER);
      ain_q      <= '0;
      bin_q      <= '0;
      win_line_q <= '0;
      winner_q   <= WIN_NONE;
      draw_q     <= 1'b0;
      illegal_q  <= 1'b0;
      mover_q    <= FIRST_PLAYER;
    end else begin
      state_q    <= state_d;
      ain_q      <= ain_d;
      bin_q      <= bin_d;
      win_line_q <= win_line_d;
      winner_q   <= winner_d;
      draw_q     <= draw_d;
      illegal_q  <= illegal_d;
      mover_q    <= mover_d;
    end
  end

  // Outputs decoded from state; turn keeps the last mover while checking or finished.
  always_comb begin
    a_ready   = (state_q == ST_TURN_A);
    b_ready   = (state_q == ST_TURN_B);
    game_over = (state_q == ST_DONE);
    turn      = (state_q == ST_TURN_B) |
                (((state_q == ST_CHECK) | (state_q == ST_DONE)) & mover_q);
    ain       = ain_q;
    bin       = bin_q;
    win_line  = win_line_q;
    winner    = winner_q;
    draw      = draw_q;
    illegal   = illegal_q;
  end

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 SHALL have parameter FIRST_PLAYER, default 0, meaning player that moves first after reset/clear (0 = A, 1 = B).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port clear  input  1  synchronous new-game request.
REQ-005 SHALL have port a_valid  input  1  player A move request.
REQ-006 SHALL have port a_pos  input  4  player A target square, 0..8.
REQ-007 SHALL have port a_ready  output  1  controller accepts A move this cycle.
REQ-008 SHALL have ports b_valid / b_pos / b_ready, identical to A ports for player B.
REQ-009 SHALL have port ain  output  9  registered A occupancy, bit i = square i.
REQ-010 SHALL have port bin  output  9  registered B occupancy.
REQ-011 SHALL have port turn  output  1  player to move (0 = A, 1 = B).
REQ-012 SHALL have port win_line  output  8  registered winning lines: bit0 row 8-7-6, bit1 row 5-4-3, bit2 row 2-1-0, bit3 col 8-5-2, bit4 col 7-4-1, bit5 col 6-3-0, bit6 diag 8-4-0, bit7 diag 2-4-6.
REQ-013 SHALL have port winner  output  2  00 none, 01 A, 10 B; 11 never driven.
REQ-014 SHALL have port draw  output  1  board full, no win.
REQ-015 SHALL have port game_over  output  1  high exactly in DONE.
REQ-016 SHALL have port illegal  output  1  one-cycle pulse on rejected move.

Function
REQ-017 SHALL implement states TURN_A, TURN_B, CHECK, DONE.
REQ-018 SHALL assert a_ready only in TURN_A and b_ready only in TURN_B; turn = 1 in TURN_B, and in CHECK/DONE SHALL hold the last mover.
REQ-019 SHALL accept a move on the cycle valid && ready; a request from the non-turn player SHALL be ignored, with no illegal pulse.
REQ-020 SHALL reject an accepted move with pos > 8 or square already set in ain|bin: board unchanged, stay in same TURN state, illegal = 1 in the following cycle.
REQ-021 SHALL, for a legal move accepted in cycle N, set the square bit at edge N+1, be in CHECK in cycle N+1, and deassert both readys in CHECK.
REQ-022 SHALL, in CHECK, evaluate the updated board: any line complete -> DONE with winner = mover and win_line = all completed lines of mover (multiple bits allowed); else board full (ain|bin = 9'h1FF) -> DONE with draw = 1; else -> other player's TURN state.
REQ-023 SHALL give a win priority over a full board (a win on the ninth move sets draw = 0).
REQ-024 SHALL hold board, winner, win_line and draw stable in DONE, deassert both readys there, and leave DONE only on clear.
REQ-025 SHALL, on clear in any state (priority over any move in the same cycle), zero ain, bin, win_line, winner, draw and illegal and enter the FIRST_PLAYER TURN state at the next edge.
REQ-026 SHALL keep win_line = 0 and winner = 00 outside DONE.

Reset
REQ-027 SHALL, while rst_n = 0, force ain = bin = 0, win_line = 0, winner = 00, draw = 0, illegal = 0, state = FIRST_PLAYER TURN state, independent of clk.
REQ-028 SHALL discard any in-flight move or CHECK on reset assertion; the first accept is possible in the first cycle after rst_n deasserts.

Structure
REQ-029 SHALL place the state encoding, winner codes (NONE/A/B), board width 9 and max position 8 in shared package ttt_pkg.
REQ-030 SHALL instantiate one combinational sub-module ttt_line_detect (9-bit board in, 8-bit line vector out, bit order per REQ-012) per player; all registers stay in ttt_game_ctrl.

Verification
REQ-031 SHALL cover: A plays 0, B plays 3, A 1, B 4, A 2 -> DONE after CHECK, winner = 01, win_line = 8'h04, game_over = 1.
REQ-032 SHALL cover: sequence A4 B0 A8 B2 A1 B7 A6 B3 A5 (board full) -> draw = 1, winner = 00, win_line = 0.
REQ-033 SHALL cover: A plays 4, then B requests 4, then B requests 9 -> illegal pulse each time, bin = 0, state stays TURN_B, then B plays 0 -> accepted.
REQ-034 SHALL cover: b_valid held high during TURN_A and CHECK -> no B accept, no illegal, board unchanged.
REQ-035 SHALL cover: clear asserted simultaneously with a legal A move, and rst_n pulsed low mid-CHECK -> board = 0, A in TURN_A, no illegal pulse.
